// File: rtl/ticket_call_queue.sv
// Ticket issue FIFO with an officer call dispatcher driving 7-segment display fields.
// Optional feature macro OFFICER_PENDING_EN: remembers unserved officer presses.
module ticket_call_queue #(
  parameter int DEPTH           = 8,
  parameter int TICKET_MAX      = 99,
  parameter int ANNOUNCE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       take_ticket_i,
  input  logic [1:0] service_req_i,
  input  logic [3:0] officer_button_i,
  output logic       ticket_issued_o,
  output logic [6:0] issued_ticket_o,
  output logic       ticket_reject_o,
  output logic       call_valid_o,
  output logic [6:0] call_ticket_o,
  output logic [1:0] call_officer_o,
  output logic [1:0] call_service_o,
  output logic [3:0] waiting_customers_o,
  output logic       queue_full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] ANNOUNCE = 1'b1;

  logic [8:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [6:0]    last_q, last_d;
  logic          take_prev_q;
  logic [3:0]    off_prev_q;
  logic [0:0]    state_q, state_d;
  logic [7:0]    ann_cnt_q, ann_cnt_d;
  logic          issued_q, issued_d;
  logic          reject_q, reject_d;
  logic [6:0]    call_ticket_q, call_ticket_d;
  logic [1:0]    call_officer_q, call_officer_d;
  logic [1:0]    call_service_q, call_service_d;

  logic       take_edge;
  logic [3:0] off_edge;
  logic [3:0] req;
  logic [1:0] grant_idx;
  logic       full;
  logic       push;
  logic       pop;
  logic       dispatch_ok;
  logic [6:0] next_ticket;

`ifdef OFFICER_PENDING_EN
  logic [3:0] pending_q, pending_d;
`endif

  always_comb begin
    take_edge   = take_ticket_i & ~take_prev_q;
    off_edge    = officer_button_i & ~off_prev_q;
`ifdef OFFICER_PENDING_EN
    req         = off_edge | pending_q;
`else
    req         = off_edge;
`endif
    full        = (count_q == CW'(DEPTH));
    next_ticket = (last_q >= 7'(TICKET_MAX)) ? 7'd1 : last_q + 7'd1;
    // The last announce cycle doubles as an idle slot so calls can run back-to-back.
    dispatch_ok = (state_q == IDLE) || (ann_cnt_q == 8'd0);
    pop         = dispatch_ok && (count_q != '0) && (req != 4'd0);
    push        = take_edge && !full;

    grant_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) grant_idx = 2'(i);
    end

    wr_ptr_d       = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d       = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d        = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
    last_d         = push ? next_ticket : last_q;
    issued_d       = push;
    reject_d       = take_edge && full;

    state_d        = state_q;
    ann_cnt_d      = ann_cnt_q;
    call_ticket_d  = call_ticket_q;
    call_officer_d = call_officer_q;
    call_service_d = call_service_q;
    if (pop) begin
      state_d        = ANNOUNCE;
      ann_cnt_d      = 8'(ANNOUNCE_CYCLES - 1);
      call_ticket_d  = mem_q[rd_ptr_q][8:2];
      call_service_d = mem_q[rd_ptr_q][1:0];
      call_officer_d = grant_idx;
    end else if (state_q == ANNOUNCE) begin
      if (ann_cnt_q == 8'd0) state_d = IDLE;
      else                   ann_cnt_d = ann_cnt_q - 8'd1;
    end

`ifdef OFFICER_PENDING_EN
    pending_d = req;
    if (pop) pending_d[grant_idx] = 1'b0;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {next_ticket, service_req_i};
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      last_q         <= 7'd0;
      take_prev_q    <= 1'b0;
      off_prev_q     <= 4'd0;
      state_q        <= IDLE;
      ann_cnt_q      <= 8'd0;
      issued_q       <= 1'b0;
      reject_q       <= 1'b0;
      call_ticket_q  <= 7'd0;
      call_officer_q <= 2'd0;
      call_service_q <= 2'd0;
`ifdef OFFICER_PENDING_EN
      pending_q      <= 4'd0;
`endif
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      last_q         <= last_d;
      take_prev_q    <= take_ticket_i;
      off_prev_q     <= officer_button_i;
      state_q        <= state_d;
      ann_cnt_q      <= ann_cnt_d;
      issued_q       <= issued_d;
      reject_q       <= reject_d;
      call_ticket_q  <= call_ticket_d;
      call_officer_q <= call_officer_d;
      call_service_q <= call_service_d;
`ifdef OFFICER_PENDING_EN
      pending_q      <= pending_d;
`endif
    end
  end

  assign ticket_issued_o     = issued_q;
  assign issued_ticket_o     = last_q;
  assign ticket_reject_o     = reject_q;
  assign call_valid_o        = (state_q == ANNOUNCE);
  assign call_ticket_o       = call_ticket_q;
  assign call_officer_o      = call_officer_q;
  assign call_service_o      = call_service_q;
  assign waiting_customers_o = 4'(count_q);
  assign queue_full_o        = full;

endmodule

// File: tb/tb_ticket_call_queue.sv
// Bench for ticket_call_queue: directed scenarios plus random button traffic against a queue model.
module tb_ticket_call_queue;

  localparam int DEPTH = 8;
  localparam int TMAX  = 99;
  localparam int ANN   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       take = 1'b0;
  logic [1:0] svc = 2'd0;
  logic [3:0] obtn = 4'd0;
  logic       issued_o, reject_o, valid_o, full_o;
  logic [6:0] issued_tk_o, call_tk_o;
  logic [1:0] call_off_o, call_svc_o;
  logic [3:0] waiting_o;

  int tests = 0;
  int failed = 0;

  ticket_call_queue #(.DEPTH(DEPTH), .TICKET_MAX(TMAX), .ANNOUNCE_CYCLES(ANN)) dut (
    .clk_i(clk), .reset_ni(rst_n), .take_ticket_i(take), .service_req_i(svc),
    .officer_button_i(obtn), .ticket_issued_o(issued_o), .issued_ticket_o(issued_tk_o),
    .ticket_reject_o(reject_o), .call_valid_o(valid_o), .call_ticket_o(call_tk_o),
    .call_officer_o(call_off_o), .call_service_o(call_svc_o),
    .waiting_customers_o(waiting_o), .queue_full_o(full_o)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of {ticket, service} and the number of announce cycles left.
  logic [8:0] m_q[$];
  int         m_left, m_last, m_ct, m_co, m_cs;
  bit         m_iss, m_rej, m_ptake;
  logic [3:0] m_poff, m_pend;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_left = 0; m_last = 0; m_ct = 0; m_co = 0; m_cs = 0;
    m_iss = 0; m_rej = 0; m_ptake = 0; m_poff = 4'd0; m_pend = 4'd0;
  endtask

  task automatic model_edge(input bit tk, input logic [1:0] sv, input logic [3:0] ob);
    bit         te;
    logic [3:0] oe, rq;
    int         sz, win;
    logic [8:0] head;
    te  = tk && !m_ptake;
    oe  = ob & ~m_poff;
`ifdef OFFICER_PENDING_EN
    rq  = oe | m_pend;
`else
    rq  = oe;
`endif
    sz  = m_q.size();
    win = -1;
    for (int i = 0; i < 4; i++) if (rq[i] && win < 0) win = i;
    if (m_left <= 1 && sz > 0 && win >= 0) begin
      head   = m_q.pop_front();
      m_ct   = int'(head[8:2]);
      m_cs   = int'(head[1:0]);
      m_co   = win;
      m_left = ANN;
      $display("[TB] call ticket %0d svc %0d to officer %0d", m_ct, m_cs, m_co);
    end else begin
      win = -1;
      if (m_left > 0) m_left--;
    end
`ifdef OFFICER_PENDING_EN
    m_pend = rq;
    if (win >= 0) m_pend[win] = 1'b0;
`endif
    m_iss = 0; m_rej = 0;
    if (te) begin
      if (sz < DEPTH) begin
        m_last = (m_last >= TMAX) ? 1 : m_last + 1;
        m_q.push_back({7'(m_last), sv});
        m_iss = 1;
        $display("[TB] issue ticket %0d svc %0d", m_last, sv);
      end else begin
        m_rej = 1;
        $display("[TB] reject take_ticket, queue full");
      end
    end
    m_ptake = tk;
    m_poff  = ob;
  endtask

  task automatic compare_all();
    check("call_valid", int'(valid_o), int'(m_left > 0));
    check("call_ticket", int'(call_tk_o), m_ct);
    check("call_officer", int'(call_off_o), m_co);
    check("call_service", int'(call_svc_o), m_cs);
    check("waiting", int'(waiting_o), m_q.size());
    check("queue_full", int'(full_o), int'(m_q.size() == DEPTH));
    check("issued_ticket", int'(issued_tk_o), m_last);
    check("ticket_issued", int'(issued_o), int'(m_iss));
    check("ticket_reject", int'(reject_o), int'(m_rej));
  endtask

  task automatic step(input bit tk, input logic [1:0] sv, input logic [3:0] ob);
    take = tk; svc = sv; obtn = ob;
    @(posedge clk);
    model_edge(tk, sv, ob);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 4'd0);
  endtask

  task automatic press_take(input logic [1:0] sv);
    step(1'b1, sv, 4'd0);
    step(1'b0, sv, 4'd0);
  endtask

  task automatic do_reset();
    take = 1'b0; obtn = 4'd0; svc = 2'd0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    model_reset();
    #3;
    check("reset_valid", int'(valid_o), 0);
    check("reset_waiting", int'(waiting_o), 0);
    check("reset_issued", int'(issued_tk_o), 0);
    do_reset();

    // Three tickets, then officer 2 takes the first.
    press_take(2'd0); press_take(2'd2); press_take(2'd1);
    check("three_issued", int'(issued_tk_o), 3);
    check("three_waiting", int'(waiting_o), 3);
    step(1'b0, 2'd0, 4'b0100);
    check("call1_valid", int'(valid_o), 1);
    check("call1_ticket", int'(call_tk_o), 1);
    check("call1_officer", int'(call_off_o), 2);
    check("call1_service", int'(call_svc_o), 0);
    check("call1_waiting", int'(waiting_o), 2);
    step(1'b0, 2'd0, 4'd0);
    idle(ANN);
    check("call1_done", int'(valid_o), 0);

    // Fill, reject, pop one, next ticket continues the sequence.
    do_reset();
    for (int i = 0; i < DEPTH; i++) press_take(2'(i));
    check("fill_full", int'(full_o), 1);
    step(1'b1, 2'd3, 4'd0);
    check("fill_reject", int'(reject_o), 1);
    check("fill_no_adv", int'(issued_tk_o), 8);
    step(1'b0, 2'd0, 4'b0001);
    step(1'b0, 2'd0, 4'd0);
    press_take(2'd1);
    check("fill_next9", int'(issued_tk_o), 9);
    idle(ANN);

    // Simultaneous officers 1 and 3 with two tickets queued.
    do_reset();
    press_take(2'd1); press_take(2'd2);
    step(1'b0, 2'd0, 4'b1010);
    check("prio_officer", int'(call_off_o), 1);
    step(1'b0, 2'd0, 4'd0);
    idle(ANN - 1);
`ifdef OFFICER_PENDING_EN
    check("pend_valid", int'(valid_o), 1);
    check("pend_officer", int'(call_off_o), 3);
`else
    check("drop_valid", int'(valid_o), 0);
    check("drop_waiting", int'(waiting_o), 1);
`endif
    idle(ANN + 2);

    // Ticket numbers wrap from TICKET_MAX to 1.
    do_reset();
    for (int i = 0; i < TMAX + 3; i++) begin
      press_take(2'(i));
      check("wrap_number", int'(issued_tk_o), (i % TMAX) + 1);
      step(1'b0, 2'd0, 4'b1000);
      step(1'b0, 2'd0, 4'd0);
      idle(ANN);
    end

    // Reset in the middle of an announce.
    press_take(2'd3); press_take(2'd2);
    step(1'b0, 2'd0, 4'b0010);
    step(1'b0, 2'd0, 4'd0);
    check("mid_valid", int'(valid_o), 1);
    do_reset();
    check("rst_call_valid", int'(valid_o), 0);
    check("rst_call_ticket", int'(call_tk_o), 0);
    check("rst_waiting", int'(waiting_o), 0);

    // Random button traffic.
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] ob;
      for (int b = 0; b < 4; b++) ob[b] = ($urandom_range(0, 5) == 0);
      step($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), ob);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ticket_call_queue.md
# ticket_call_queue

Customer-facing counterpart of the bank ticket dispenser. It issues sequentially numbered tickets when a customer presses the take-ticket button and buffers them in a FIFO. It then calls the oldest waiting ticket to whichever officer presses a "next customer" button. Its outputs drive the same 7-segment display decoders used for ticket, officer, service and waiting-count fields.

## Interface
- `DEPTH`, default 8: queue entries; power of two, 2..8.
- `TICKET_MAX`, default 99: highest ticket number; the counter wraps to 1 after it.
- `ANNOUNCE_CYCLES`, default 4: cycles `call_valid` is held for each call; legal range 1..255.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `take_ticket` input 1: customer button, level; a rising edge requests a ticket.
- `service_req` input 2: service type A..D (0..3); sampled with the take_ticket edge.
- `officer_button` input 4: officer "next" buttons, level; a rising edge on bit i is a request from officer i.
- `ticket_issued` output 1: one-cycle pulse when a ticket is enqueued.
- `issued_ticket` output 7: number of the last issued ticket.
- `ticket_reject` output 1: one-cycle pulse when a take_ticket edge hits a full queue.
- `call_valid` output 1: high during the announce window.
- `call_ticket` output 7: ticket number being (or last) called.
- `call_officer` output 2: officer the ticket was called to.
- `call_service` output 2: service type of the called ticket.
- `waiting_customers` output 4: current queue occupancy, 0..DEPTH.
- `queue_full` output 1: asserted when occupancy equals DEPTH.

## Operation
- Edge detect: both button inputs are registered once; edge = `in & ~prev`. A held button produces exactly one edge.
- Issue path, on a take_ticket edge:
  - If the queue is not full: the next ticket number is computed (last+1, or 1 after TICKET_MAX). The entry {ticket, service_req} is pushed. `issued_ticket` is updated and `ticket_issued` pulses.
  - If the queue is full: nothing is pushed, the ticket counter does not advance, and `ticket_reject` pulses.
- Dispatch FSM has two states: IDLE and ANNOUNCE.
  - IDLE to ANNOUNCE: an officer request is present and the queue is non-empty.
  - On that transition: pop the head entry and load `call_ticket`, `call_service`, and `call_officer` with the requesting officer's index. Load the announce counter with ANNOUNCE_CYCLES-1.
  - ANNOUNCE: `call_valid`=1. The counter decrements each cycle. At 0 the FSM returns to IDLE.
- Several officer requests in the same cycle: the lowest index wins.
- Requests that are not served (FSM in ANNOUNCE, queue empty, or lost the priority pick) are handled as described under Configuration.
- Push and pop in the same cycle: occupancy is unchanged.
- There is no bypass. A ticket pushed in cycle k is poppable from cycle k+1 at the earliest.
- Occupancy arithmetic never wraps. A pop only happens when count>0; a push only when count<DEPTH.
- FIFO pointers are log2(DEPTH) bits and wrap naturally.
- Call outputs hold their last values after `call_valid` drops.
- Reset values (all outputs and state):
  - Outputs `issued_ticket`, `call_ticket`, `call_officer`, `call_service`, `waiting_customers`, `call_valid`, `ticket_issued` and `ticket_reject` reset to 0.
  - `queue_full` resets to 0.
  - The FSM resets to IDLE.
  - Pointers, the ticket counter and the edge-detect registers reset to 0.
  - Pending mask resets to 0 when the feature is enabled.
- Reset asserted mid-announce or mid-push aborts immediately. Queue contents are discarded.

## Timing
- take_ticket edge sampled at rising edge k: `ticket_issued` is high during cycle k to k+1, and `waiting_customers` is updated after edge k.
- Officer edge at edge k with the FSM in IDLE and the queue non-empty: the call outputs update and `call_valid` rises after edge k. `call_valid` stays high for exactly ANNOUNCE_CYCLES cycles.
- Earliest next call: the edge at which the FSM re-enters IDLE, i.e. back-to-back calls are separated by 0 idle cycles.

## Configuration
- `OFFICER_PENDING_EN` defined: unserved officer edges set bits in a 4-bit pending mask.
  - In IDLE with a non-empty queue, the lowest set pending bit, OR'd with new edges, is served and then cleared.
  - An officer who pressed while the queue was empty is called automatically when a ticket arrives.
- `OFFICER_PENDING_EN` undefined: unserved officer edges are dropped. Only a fresh edge in IDLE with a non-empty queue causes a call.

## Test plan
- Reset, then three take_ticket edges with service 0,2,1. Expect `issued_ticket` 1,2,3, three `ticket_issued` pulses, and `waiting_customers`=3.
- Then `officer_button`=4'b0100 edge. Expect `call_valid` high for 4 cycles with call_ticket=1, call_officer=2, call_service=0, and `waiting_customers`=2.
- Fill to 8 entries, then a 9th take_ticket. Expect `ticket_reject` pulse, `queue_full`=1, no counter advance; the next accepted ticket after one pop is 9.
- Simultaneous edges on officer buttons 1 and 3 with 2 tickets queued:
  - Officer 1 is called first.
  - With `OFFICER_PENDING_EN`, officer 3 is called right after the announce ends.
  - Without it, officer 3 is not called.
- Issue tickets past TICKET_MAX=99. Expect ticket 99 to be followed by 1.
- Assert reset during ANNOUNCE. Expect all outputs 0, queue empty, and the FSM in IDLE.
